// File: rtl/ecdsa_dma_arbiter.sv
// Round-robin arbiter sharing one 381-bit DMA channel among NUM_REQ ECDSA clients.
// Handshake: a client holds req until done[i] pulses; it must drop req on that same edge.
module ecdsa_dma_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [381*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [380:0]           rdata,
    input  logic [380:0]           dma_rx_data,
    output logic [380:0]           dma_tx_data,
    output logic [31:0]            dma_rx_address,
    output logic [31:0]            dma_tx_address,
    output logic                   dma_rx_start,
    output logic                   dma_tx_start,
    input  logic                   dma_done,
    input  logic                   dma_idle,
    input  logic                   dma_error,
    output logic [1:0]             state_dbg
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, idx, win, cand;
    logic            wr_lat, found, timed_out, first;
    logic [CW-1:0]   cnt;

    assign state_dbg = state;
    // The registered start pulse marks the first WAIT cycle, where dma_done is ignored.
    assign first = dma_rx_start | dma_tx_start;

    always_comb begin
        state_n   = state;
        win       = ptr;
        cand      = '0;
        found     = 1'b0;
        timed_out = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        case (state)
            S_IDLE:  if (found) state_n = S_START;
            S_START: if (dma_idle) state_n = S_WAIT;
            S_WAIT: begin
                if (!first) begin
                    if (dma_done) begin
                        state_n = S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state_n   = S_RESP;
                        timed_out = 1'b1;
                    end
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            ptr            <= IW'(NUM_REQ - 1);
            idx            <= '0;
            wr_lat         <= 1'b0;
            cnt            <= '0;
            gnt            <= '0;
            done           <= '0;
            err            <= 1'b0;
            rdata          <= '0;
            dma_tx_data    <= '0;
            dma_rx_address <= '0;
            dma_tx_address <= '0;
            dma_rx_start   <= 1'b0;
            dma_tx_start   <= 1'b0;
        end else begin
            state        <= state_n;
            dma_rx_start <= 1'b0;
            dma_tx_start <= 1'b0;
            done         <= '0;
            err          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        idx            <= win;
                        wr_lat         <= req_wr[win];
                        dma_rx_address <= req_addr[32*int'(win) +: 32];
                        dma_tx_address <= req_addr[32*int'(win) +: 32];
                        dma_tx_data    <= req_wdata[381*int'(win) +: 381];
                        gnt            <= NUM_REQ'(1) << win;
                    end
                end
                S_START: begin
                    if (dma_idle) begin
                        dma_rx_start <= !wr_lat;
                        dma_tx_start <= wr_lat;
                        cnt          <= '0;
                    end
                end
                S_WAIT: begin
                    if (state_n == S_RESP) begin
                        done <= NUM_REQ'(1) << idx;
                        err  <= timed_out | dma_error;
                        if (!timed_out && !wr_lat) rdata <= dma_rx_data;
                    end else if (!first) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    ptr <= idx;
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecdsa_dma_arbiter.sv
// Directed bench for ecdsa_dma_arbiter: rx/tx transfers, round-robin order, busy DMA,
// error and timeout aborts, and reset in the middle of a transfer.
module tb_ecdsa_dma_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, req_wr;
    logic [32*N-1:0]  req_addr;
    logic [381*N-1:0] req_wdata;
    logic [N-1:0]     gnt, done;
    logic             err;
    logic [380:0]     rdata, dma_rx_data, dma_tx_data;
    logic [31:0]      dma_rx_address, dma_tx_address;
    logic             dma_rx_start, dma_tx_start;
    logic             dma_done, dma_idle, dma_error;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] e;
    logic [380:0] ones;

    ecdsa_dma_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .dma_rx_data(dma_rx_data), .dma_tx_data(dma_tx_data),
        .dma_rx_address(dma_rx_address), .dma_tx_address(dma_tx_address),
        .dma_rx_start(dma_rx_start), .dma_tx_start(dma_tx_start),
        .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [380:0] obs, input logic [380:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_client(input int i, input logic wr, input logic [31:0] a,
                              input logic [380:0] d);
        req_wr[i]           = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[381*i +: 381] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rxs"}, dma_rx_start, 0);
        chk({tag, "_txs"}, dma_tx_start, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_txd"}, dma_tx_data, 0);
        chk({tag, "_rxa"}, dma_rx_address, 0);
        chk({tag, "_txa"}, dma_tx_address, 0);
    endtask

    initial begin
        ones = '1;
        reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        dma_rx_data = '0; dma_done = 1'b0; dma_idle = 1'b1; dma_error = 1'b0;
        tick(); tick();
        chk_all_zero("reset");

        // Single rx, client 2
        reset = 1'b0;
        set_client(2, 1'b0, 32'h1000, 381'h0);
        req[2] = 1'b1;
        tick();
        chk("rx_gnt", gnt, 4'b0100);
        chk("rx_nostart", dma_rx_start, 0);
        tick();
        chk("rx_start", dma_rx_start, 1);
        chk("rx_txstart", dma_tx_start, 0);
        chk("rx_addr", dma_rx_address, 32'h1000);
        chk("rx_txaddr", dma_tx_address, 32'h1000);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 1) chk("rx_start_once", dma_rx_start, 0);
            chk("rx_wait_done", done, 0);
        end
        tick();
        dma_done = 1'b1; dma_rx_data = 381'h1234;
        tick();
        chk("rx_done", done, 4'b0100);
        chk("rx_rdata", rdata, 381'h1234);
        chk("rx_err", err, 0);
        chk("rx_gnt_resp", gnt, 4'b0100);
        dma_done = 1'b0; req[2] = 1'b0;
        tick();
        chk("rx_gnt_clr", gnt, 0);
        chk("rx_done_clr", done, 0);

        // Single tx, client 1; dma_done in first WAIT cycle must be ignored
        set_client(1, 1'b1, 32'h2000, ones);
        req[1] = 1'b1;
        tick();
        chk("tx_gnt", gnt, 4'b0010);
        tick();
        chk("tx_start", dma_tx_start, 1);
        chk("tx_rxstart", dma_rx_start, 0);
        chk("tx_data", dma_tx_data, ones);
        chk("tx_addr", dma_tx_address, 32'h2000);
        dma_done = 1'b1;
        tick();
        chk("tx_first_ignored", done, 0);
        tick();
        chk("tx_done", done, 4'b0010);
        chk("tx_rdata_keep", rdata, 381'h1234);
        chk("tx_err", err, 0);
        dma_done = 1'b0; req[1] = 1'b0;
        tick();
        chk("tx_gnt_clr", gnt, 0);

        // Busy DMA with spurious done/error during START, then error completion
        dma_idle = 1'b0;
        set_client(0, 1'b0, 32'h3000, 381'h0);
        req[0] = 1'b1;
        tick();
        chk("busy_gnt", gnt, 4'b0001);
        for (int j = 0; j < 10; j++) begin
            dma_done  = (j == 3);
            dma_error = (j == 3);
            tick();
            chk("busy_nostart", dma_rx_start, 0);
            chk("busy_gnt_hold", gnt, 4'b0001);
            chk("busy_nodone", done, 0);
        end
        dma_done = 1'b0; dma_error = 1'b0; dma_idle = 1'b1;
        tick();
        chk("busy_start", dma_rx_start, 1);
        dma_done = 1'b1; dma_error = 1'b1; dma_rx_data = 381'hABCD;
        tick();
        chk("err_first_ignored", done, 0);
        tick();
        chk("err_done", done, 4'b0001);
        chk("err_flag", err, 1);
        chk("err_rdata", rdata, 381'hABCD);
        dma_done = 1'b0; dma_error = 1'b0; req[0] = 1'b0;
        tick();
        chk("err_gnt_clr", gnt, 0);

        // Timeout on client 3 (tx); client 0 waits and is served next
        set_client(3, 1'b1, 32'h4000, 381'h55);
        set_client(0, 1'b0, 32'h5000, 381'h0);
        req = 4'b1001;
        tick();
        chk("to_gnt", gnt, 4'b1000);
        tick();
        chk("to_start", dma_tx_start, 1);
        for (int j = 1; j <= TO; j++) begin
            tick();
            chk("to_wait", done, 0);
        end
        tick();
        chk("to_done", done, 4'b1000);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 381'hABCD);
        req[3] = 1'b0;
        tick();
        chk("to_idle", gnt, 0);
        tick();
        chk("to_next_gnt", gnt, 4'b0001);
        tick();
        chk("to_next_start", dma_rx_start, 1);
        chk("to_next_addr", dma_rx_address, 32'h5000);
        tick();
        dma_done = 1'b1; dma_rx_data = 381'h777;
        tick();
        chk("to_next_done", done, 4'b0001);
        chk("to_next_err", err, 0);
        chk("to_next_rdata", rdata, 381'h777);
        dma_done = 1'b0; req[0] = 1'b0;
        tick();

        // Round-robin with all clients requesting after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_wr = '0;
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            chk("rr_gnt", gnt, e);
            tick();
            chk("rr_start", dma_rx_start, 1);
            tick();
            dma_done = 1'b1;
            tick();
            chk("rr_done", done, e);
            dma_done = 1'b0;
            req = req & ~e;
            tick();
            chk("rr_idle", gnt, 0);
            req = req | e;
        end

        // Reset in the middle of WAIT, then client 3 alone
        req = 4'b0100;
        tick();
        chk("mr_gnt", gnt, 4'b0100);
        tick();
        chk("mr_start", dma_rx_start, 1);
        tick();
        reset = 1'b1; req = '0;
        tick();
        chk_all_zero("mr_reset");
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("mr_nodone", done, 0);
            chk("mr_nognt", gnt, 0);
        end
        set_client(3, 1'b0, 32'h6000, 381'h0);
        req[3] = 1'b1;
        tick();
        chk("mr3_gnt", gnt, 4'b1000);
        tick();
        chk("mr3_start", dma_rx_start, 1);
        chk("mr3_addr", dma_rx_address, 32'h6000);
        tick();
        dma_done = 1'b1; dma_rx_data = 381'h99;
        tick();
        chk("mr3_done", done, 4'b1000);
        chk("mr3_rdata", rdata, 381'h99);
        dma_done = 1'b0; req[3] = 1'b0;
        tick();
        chk("mr3_gnt_clr", gnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
